// File: rtl/game_session_if.sv
// Bundle of player-side and game-side signals shared by the session controller.
// The controller uses the slave modport and the environment uses the master modport.
interface game_session_if #(
  parameter int NUM_GAMES = 2
);
  logic                     tick;
  logic [2:0]               buttons;
  logic                     login_valid;
  logic [15:0]              login_userid;
  logic                     abort;
  logic                     pause_req;
  logic [NUM_GAMES-1:0]     game_eog_in;
  logic [32*NUM_GAMES-1:0]  game_data_in;
  logic [64*NUM_GAMES-1:0]  game_display_in;
  logic [NUM_GAMES-1:0]     game_rst;
  logic [1:0]               gamestate;
  logic [2:0]               game_buttons;
  logic [15:0]              game_userid;
  logic [63:0]              display_out;
  logic                     score_valid;
  logic [31:0]              score_data;
  logic [1:0]               sel;
  logic                     busy;

  modport master (
    output tick, buttons, login_valid, login_userid, abort, pause_req,
           game_eog_in, game_data_in, game_display_in,
    input  game_rst, gamestate, game_buttons, game_userid, display_out,
           score_valid, score_data, sel, busy
  );

  modport slave (
    input  tick, buttons, login_valid, login_userid, abort, pause_req,
           game_eog_in, game_data_in, game_display_in,
    output game_rst, gamestate, game_buttons, game_userid, display_out,
           score_valid, score_data, sel, busy
  );
endinterface

// File: rtl/game_session_ctrl.sv
// Session controller: login, game selection, run/pause sequencing, score capture
// and display muxing for up to four game slots sharing one 8x8 display.
module game_session_ctrl #(
  parameter int NUM_GAMES    = 2,
  parameter int IDLE_TIMEOUT = 255,
  parameter int SCORE_HOLD   = 8
) (
  input  logic          clk,
  input  logic          rst,
  game_session_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_RUN, S_PAUSE, S_END} state_t;

  localparam logic [1:0] LAST_SEL = 2'(NUM_GAMES - 1);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] uid_q, uid_d;
  logic [2:0]  btn_q, btn_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] frz_q, frz_d;
  logic        sv_q, sv_d;
  logic [31:0] sd_q, sd_d;

  logic [3:0]  eog4;
  logic [15:0] score4 [4];
  logic [63:0] disp4  [4];
  logic [2:0]  rise;
  logic        slot_on;
  logic        tmo_hit;
  logic        hold_hit;
  logic        eog_sel;

  // Slots are padded to four entries so the 2-bit sel indexes them directly;
  // only the low 16 bits of each slot's data word (its score) are consumed.
  for (genvar g = 0; g < 4; g++) begin : g_slot
    if (g < NUM_GAMES) begin : g_used
      logic unused_uid_bits;
      assign eog4[g]         = bus.game_eog_in[g];
      assign score4[g]       = bus.game_data_in[32*g +: 16];
      assign disp4[g]        = bus.game_display_in[64*g +: 64];
      assign unused_uid_bits = ^bus.game_data_in[32*g+16 +: 16];
      assign bus.game_rst[g] = slot_on && (sel_q == 2'(g));
    end else begin : g_unused
      assign eog4[g]   = 1'b0;
      assign score4[g] = '0;
      assign disp4[g]  = '0;
    end
  end

  assign rise     = bus.buttons & ~btn_q;
  assign eog_sel  = eog4[sel_q];
  assign tmo_hit  = bus.tick && (rise == 3'b000) && (cnt_q == 8'(IDLE_TIMEOUT - 1));
  assign hold_hit = bus.tick && (cnt_q == 8'(SCORE_HOLD - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort outranks every other transition
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.login_valid) state_d = S_SELECT;
        S_SELECT: if (rise[2])         state_d = S_RUN;
                  else if (tmo_hit)    state_d = S_IDLE;
        S_RUN:    if (eog_sel)         state_d = S_END;
                  else if (bus.pause_req) state_d = S_PAUSE;
        S_PAUSE:  if (eog_sel)         state_d = S_END;
                  else if (tmo_hit)    state_d = S_IDLE;
                  else if (!bus.pause_req) state_d = S_RUN;
        S_END:    if (hold_hit)        state_d = S_IDLE;
        default:                       state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: selection, userid latch, tick counter, score capture
  always_comb begin
    sel_d = sel_q;
    uid_d = uid_q;
    btn_d = bus.buttons;
    cnt_d = cnt_q;
    frz_d = frz_q;
    sv_d  = 1'b0;
    sd_d  = sd_q;
    if (state_q == S_IDLE && bus.login_valid) begin
      uid_d = bus.login_userid;
      sel_d = 2'd0;
    end
    if (state_q == S_SELECT && state_d == S_SELECT && rise[0]) begin
      sel_d = (sel_q == LAST_SEL) ? 2'd0 : sel_q + 2'd1;
    end
    // One counter serves both the idle timeout and the END hold time
    if (state_d != state_q ||
        ((state_q == S_SELECT || state_q == S_PAUSE) && rise != 3'b000)) begin
      cnt_d = 8'd0;
    end else if (bus.tick && cnt_q != 8'hFF &&
                 (state_q == S_SELECT || state_q == S_PAUSE || state_q == S_END)) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (state_d == S_END && state_q != S_END) begin
      sv_d  = 1'b1;
      sd_d  = {uid_q, score4[sel_q]};
      frz_d = disp4[sel_q];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      uid_q <= '0;
      btn_q <= '0;
      cnt_q <= '0;
      frz_q <= '0;
      sv_q  <= 1'b0;
      sd_q  <= '0;
    end else begin
      sel_q <= sel_d;
      uid_q <= uid_d;
      btn_q <= btn_d;
      cnt_q <= cnt_d;
      frz_q <= frz_d;
      sv_q  <= sv_d;
      sd_q  <= sd_d;
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    slot_on          = (state_q == S_RUN) || (state_q == S_PAUSE) || (state_q == S_END);
    bus.busy         = (state_q != S_IDLE);
    bus.gamestate    = 2'd0;
    bus.game_buttons = 3'b000;
    bus.display_out  = disp4[sel_q];
    case (state_q)
      S_IDLE:  bus.display_out = '0;
      S_RUN: begin
        bus.gamestate    = 2'd1;
        bus.game_buttons = bus.buttons;
      end
      S_PAUSE: bus.gamestate = 2'd2;
      S_END: begin
        bus.gamestate   = 2'd3;
        bus.display_out = frz_q;
      end
      default: ;
    endcase
    bus.sel         = sel_q;
    bus.game_userid = uid_q;
    bus.score_valid = sv_q;
    bus.score_data  = sd_q;
  end
endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl with two game slots.
module tb_game_session_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  game_session_if #(.NUM_GAMES(2)) bus ();

  game_session_ctrl #(
    .NUM_GAMES(2), .IDLE_TIMEOUT(255), .SCORE_HOLD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] DISP0 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] DISP1 = 64'hAAAA_AAAA_AAAA_AAAA;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int b);
    bus.buttons = 3'(1 << b);
    cyc(1);
    bus.buttons = 3'b000;
    cyc(1);
  endtask

  task automatic login(input logic [15:0] uid);
    bus.login_valid  = 1'b1;
    bus.login_userid = uid;
    cyc(1);
    bus.login_valid  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.buttons = 3'b000;
    bus.login_valid = 1'b0;
    bus.login_userid = 16'h0000;
    bus.abort = 1'b0;
    bus.pause_req = 1'b0;
    bus.game_eog_in = 2'b00;
    bus.game_data_in = {32'h1234_0077, 32'h0000_0042};
    bus.game_display_in = {DISP1, DISP0};
    cyc(3);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_disp", bus.display_out, 64'd0);
    chk("rst_grst", 64'(bus.game_rst), 64'd0);
    chk("rst_score", 64'(bus.score_data), 64'd0);
    rst = 1'b0;
    cyc(1);

    // Login and select slot 1
    login(16'hBEEF);
    chk("login_uid", 64'(bus.game_userid), 64'hBEEF);
    chk("login_busy", 64'(bus.busy), 64'd1);
    chk("sel_disp0", bus.display_out, DISP0);
    chk("sel_grst", 64'(bus.game_rst), 64'd0);
    press(0);
    chk("sel_inc", 64'(bus.sel), 64'd1);
    chk("sel_disp1", bus.display_out, DISP1);
    bus.buttons = 3'b100;
    cyc(1);
    chk("run_gs", 64'(bus.gamestate), 64'd1);
    chk("run_grst", 64'(bus.game_rst), 64'b10);
    chk("run_btn", 64'(bus.game_buttons), 64'b100);
    bus.buttons = 3'b000;
    cyc(1);

    // Abort beats eog in RUN, no score pulse
    bus.abort = 1'b1;
    bus.game_eog_in = 2'b10;
    cyc(1);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_sv", 64'(bus.score_valid), 64'd0);
    chk("abort_grst", 64'(bus.game_rst), 64'd0);
    chk("abort_disp", bus.display_out, 64'd0);
    bus.abort = 1'b0;
    bus.game_eog_in = 2'b00;
    cyc(1);
    chk("abort_sd", 64'(bus.score_data), 64'd0);

    // Selection wrap, ignored re-login, simultaneous confirm
    login(16'hBEEF);
    chk("wrap_sel0", 64'(bus.sel), 64'd0);
    login(16'h1111);
    chk("relogin_uid", 64'(bus.game_userid), 64'hBEEF);
    press(0);
    chk("wrap_a", 64'(bus.sel), 64'd1);
    press(0);
    chk("wrap_b", 64'(bus.sel), 64'd0);
    press(0);
    chk("wrap_c", 64'(bus.sel), 64'd1);
    bus.buttons = 3'b101;
    cyc(1);
    chk("both_gs", 64'(bus.gamestate), 64'd1);
    chk("both_sel", 64'(bus.sel), 64'd1);
    bus.buttons = 3'b000;
    cyc(1);

    // Pause and resume
    bus.pause_req = 1'b1;
    cyc(1);
    chk("pause_gs", 64'(bus.gamestate), 64'd2);
    chk("pause_grst", 64'(bus.game_rst), 64'b10);
    bus.buttons = 3'b111;
    #1;
    chk("pause_btn", 64'(bus.game_buttons), 64'd0);
    bus.buttons = 3'b000;
    bus.pause_req = 1'b0;
    cyc(1);
    chk("resume_gs", 64'(bus.gamestate), 64'd1);
    bus.game_eog_in = 2'b01;
    cyc(1);
    chk("eog_other", 64'(bus.gamestate), 64'd1);

    // eog and pause together: END wins, score captured, display frozen
    bus.game_eog_in = 2'b10;
    bus.pause_req = 1'b1;
    cyc(1);
    chk("end_gs", 64'(bus.gamestate), 64'd3);
    chk("end_sv", 64'(bus.score_valid), 64'd1);
    chk("end_sd", 64'(bus.score_data), 64'hBEEF_0077);
    bus.game_display_in = {64'h1111_1111_1111_1111, DISP0};
    #1;
    chk("end_frz", bus.display_out, DISP1);
    bus.game_eog_in = 2'b00;
    bus.pause_req = 1'b0;
    cyc(1);
    chk("end_sv_off", 64'(bus.score_valid), 64'd0);
    bus.tick = 1'b1;
    cyc(7);
    chk("hold_7", 64'(bus.gamestate), 64'd3);
    cyc(1);
    bus.tick = 1'b0;
    chk("hold_busy", 64'(bus.busy), 64'd0);
    chk("hold_grst", 64'(bus.game_rst), 64'd0);
    chk("hold_disp", bus.display_out, 64'd0);
    chk("hold_sd", 64'(bus.score_data), 64'hBEEF_0077);
    bus.game_display_in = {DISP1, DISP0};

    // Score capture on slot 0, then abort out of END
    login(16'hBEEF);
    press(2);
    chk("s0_grst", 64'(bus.game_rst), 64'b01);
    bus.game_eog_in = 2'b01;
    cyc(1);
    bus.game_eog_in = 2'b00;
    chk("s0_sv", 64'(bus.score_valid), 64'd1);
    chk("s0_sd", 64'(bus.score_data), 64'hBEEF_0042);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    chk("s0_abort", 64'(bus.busy), 64'd0);
    chk("s0_sv_off", 64'(bus.score_valid), 64'd0);

    // Timeout in SELECT with a restart on tick 255
    login(16'hCAFE);
    bus.tick = 1'b1;
    cyc(254);
    chk("tmo_254", 64'(bus.busy), 64'd1);
    bus.buttons = 3'b001;
    cyc(1);
    bus.buttons = 3'b000;
    chk("tmo_restart", 64'(bus.busy), 64'd1);
    cyc(254);
    chk("tmo_254b", 64'(bus.busy), 64'd1);
    cyc(1);
    bus.tick = 1'b0;
    chk("tmo_busy", 64'(bus.busy), 64'd0);
    chk("tmo_disp", bus.display_out, 64'd0);

    // Asynchronous reset mid-RUN
    login(16'hBEEF);
    press(2);
    chk("pre_rst_gs", 64'(bus.gamestate), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gs", 64'(bus.gamestate), 64'd0);
    chk("arst_grst", 64'(bus.game_rst), 64'd0);
    chk("arst_uid", 64'(bus.game_userid), 64'd0);
    chk("arst_sd", 64'(bus.score_data), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
Session controller that sequences the game modules sharing the 8x8 display and button inputs. It latches the logged-in userid, lets the player pick one of NUM_GAMES games, and holds the other games in reset. It drives gamestate, routes buttons to the active game, muxes its display and captures the final score when game_eog rises.

Parameters:
NUM_GAMES, 2, number of game slots (1..4); sel width is 2 bits regardless
IDLE_TIMEOUT, 255, ticks without a button edge in SELECT/PAUSE before returning to IDLE (8-bit counter)
SCORE_HOLD, 8, ticks the final display is frozen in END before returning to IDLE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle timer strobe; all tick counts advance only on tick=1
buttons  in  3  raw player buttons, synchronous to clk
login_valid  in  1  one-cycle strobe: login_userid is valid
login_userid  in  16  user id from login logic
abort  in  1  level; forces return to IDLE
pause_req  in  1  level; requests pause while RUN
game_eog_in  in  NUM_GAMES  end-of-game flag per slot
game_data_in  in  32*NUM_GAMES  {userid,score} per slot; slot i at [32i+31:32i]
game_display_in  in  64*NUM_GAMES  display per slot; slot i at [64i+63:64i]
game_rst  out  NUM_GAMES  per-slot reset, active-low (0 = slot held in reset)
gamestate  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE; to selected slot
game_buttons  out  3  buttons forwarded to the selected slot
game_userid  out  16  latched userid
display_out  out  64  display to LED driver
score_valid  out  1  one-cycle pulse on score capture
score_data  out  32  {latched userid, captured score[15:0]}
sel  out  2  currently selected slot
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; game_rst=0; gamestate=0; game_buttons=0; game_userid=0; display_out=0; score_valid=0; score_data=0; sel=0; busy=0; counters and edge registers=0.
- Button edge detect: btn_q registered each clk; rise = buttons & ~btn_q. Used only in SELECT/PAUSE.
- IDLE: all game_rst=0, display_out=0. On login_valid: latch login_userid into game_userid, set sel=0, go to SELECT. login_valid is ignored in all other states.
- SELECT: display_out = game_display_in of sel; game_rst all 0.
  - rise[0]: sel increments and wraps NUM_GAMES-1 -> 0.
  - rise[2]: go to RUN; game_rst[sel]=1 from the next cycle.
  - rise[0] and rise[2] in the same cycle: confirm wins, sel unchanged.
- RUN: gamestate=1; game_buttons=buttons combinationally while in RUN, otherwise 0; display_out = selected slot display; only game_rst[sel]=1.
  - game_eog_in[sel]=1: go to END.
  - else pause_req=1: go to PAUSE.
  - eog and pause in the same cycle: END wins. eog from unselected slots is ignored.
- PAUSE: gamestate=2; game_rst[sel] stays 1; game_buttons=0. pause_req=0 returns to RUN next cycle. game_eog_in[sel]=1 goes to END.
- END entry cycle:
  - score_data = {game_userid, game_data_in[sel][15:0]}; score_valid=1 for exactly that cycle.
  - display_out is frozen (registered copy).
  - gamestate=3; game_rst[sel] stays 1.
  - After SCORE_HOLD ticks, go to IDLE and assert game_rst=0.
- Timeout: 8-bit counter cleared on state entry and on any rise; increments on tick in SELECT/PAUSE and saturates. Reaching IDLE_TIMEOUT goes to IDLE.
- abort=1 in any non-IDLE state: IDLE next cycle with all game_rst=0. Priority over every other transition, including eog. No score_valid is issued on abort.
- score_data holds its last value until the next capture or reset.
- Reset mid-operation: immediate return to reset values; no pulse is emitted.

Test Plan:
- Login and select: login_valid with userid 0xBEEF, rise[0] once, rise[2] -> sel=1, game_userid=0xBEEF, game_rst=2'b10, gamestate=1 one cycle after confirm.
- Select wrap: NUM_GAMES=2, three rise[0] edges -> sel sequence 1, 0, 1; simultaneous rise[0]+rise[2] with sel=1 -> RUN with sel=1.
- Score capture: RUN slot 0, game_data_in[15:0]=0x0042, game_eog_in[0]=1 -> score_valid one cycle with score_data=0xBEEF0042. After 8 ticks: IDLE, game_rst=0, display_out=0.
- Pause/eog priority: pause_req and game_eog_in[sel] both rise the same cycle -> END, gamestate=3. Separately, pause_req=1 -> gamestate=2, game_buttons=0; release -> gamestate=1.
- Timeout: in SELECT, no buttons for 255 ticks -> IDLE, busy=0; a rise at tick 254 restarts the count.
- Abort/reset: abort in RUN -> IDLE next cycle, no score_valid. rst pulse asserted between clock edges -> all outputs at reset values immediately.
